ysyx_25070198_lsu: RTL and testbench
====================================

# ysyx_25070198_lsu

Parametrised load/store unit that replaces direct per-cycle DPI memory access with a multi-cycle, handshaked data-memory path. It sits between the EXU (request/response channels) and the data-memory bus (request plus response-valid). It supports byte, half, word and (XLEN=64) double accesses with sign or zero extension and byte-lane store masks. It detects misalignment, bus errors and response timeouts.

## Interface
- XLEN, 32, data width; 32 or 64
- AW, 32, address width
- TIMEOUT, 255, max cycles in REQ+WAIT before abort; ≥2
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  1  EXU request valid
- req_ready  out  1  unit can accept request
- req_wen  in  1  1=store, 0=load
- req_size  in  2  0=B, 1=H, 2=W, 3=D
- req_unsigned  in  1  zero-extend load
- req_addr  in  AW  byte address
- req_wdata  in  XLEN  store data, LSB-aligned
- resp_valid  out  1  result valid
- resp_ready  in  1  EXU accepts result
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors
- resp_err  out  2  0=ok, 1=misaligned/illegal size, 2=bus error, 3=timeout
- mem_valid  out  1  bus request valid
- mem_ready  in  1  bus accepts request
- mem_wen  out  1  write request
- mem_addr  out  AW  address, low log2(XLEN/8) bits forced 0
- mem_wdata  out  XLEN  lane-shifted store data
- mem_wmask  out  XLEN/8  byte-enable
- mem_rvalid  in  1  bus response, one cycle, also acks writes
- mem_rdata  in  XLEN  read data, full aligned word
- mem_err  in  1  error, qualified by mem_rvalid

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: req_ready=1. On req_valid: latch all req fields.
  - Misaligned access (addr not multiple of 2^size) goes to RESP with err=1. So does size=3 with XLEN=32. No bus activity.
  - Otherwise go to REQ.
- REQ: mem_valid=1 with stable addr/wdata/wmask/wen. On mem_ready go to WAIT.
- WAIT: on mem_rvalid go to RESP.
  - err=2 if mem_err.
  - Else for loads, rdata = mem_rdata >> (off*8), truncated to 2^size bytes, then extended (sign unless req_unsigned).
- RESP: resp_valid=1 with rdata/err held. On resp_ready go to IDLE.
- Timeout counter:
  - Cleared on entering REQ; increments each cycle in REQ or WAIT.
  - At TIMEOUT: go to RESP, err=3, mem_valid drops.
  - The bus must not respond to an aborted request. mem_rvalid outside WAIT is ignored.
- Store lanes: off = addr[log2(XLEN/8)-1:0], mem_wdata = req_wdata << off*8, mem_wmask = ((1<<2^size)-1) << off.
- One outstanding transaction; responses in order.

## Timing
- Reset values:
  - state IDLE, req_ready=1.
  - resp_valid, mem_valid, mem_wen, resp_err = 0.
  - rdata, addr, wdata, wmask = 0.
  - Counter = 0.
- Reset asserted mid-transaction: outputs return to reset values immediately and the transaction is abandoned.
- Minimum aligned latency, with request accepted at cycle t:
  - mem_valid at t+1.
  - mem_ready at t+1 gives earliest mem_rvalid at t+2.
  - resp_valid at t+3.
- Misaligned latency: resp_valid at t+1.
- mem_rvalid in the same cycle as the mem_ready handshake is illegal; it is ignored.
- No back-to-back acceptance: req_ready=0 from the acceptance cycle+1 until the cycle after resp handshake.
- resp_valid is held indefinitely until resp_ready; no field changes while held.
- mem_rvalid coinciding with timeout expiry in WAIT: the response wins, err≠3.

## Structure
- Shared package ysyx_25070198_pkg holds:
  - lsu_state_e
  - size codes (SZ_B/H/W/D)
  - error codes (LSU_OK, LSU_MISALIGN, LSU_BUSERR, LSU_TIMEOUT)
- Sub-module ysyx_25070198_lsu_align: combinational store lane shift/mask and load shift/extend, parametrised by XLEN.

## Test plan
- Load, unsigned byte:
  - Stimulus: XLEN=32, lbu at 0x80000003, mem_rdata=0x80FF_1234, zero-wait bus.
  - Response: mem_addr=0x80000000, resp_rdata=0x0000_0080, err=0, resp_valid 3 cycles after accept.
- Load, signed half:
  - Stimulus: lh at 0x80000002, mem_rdata=0x8001_0000.
  - Response: resp_rdata=0xFFFF_8001.
- Store, byte:
  - Stimulus: sb 0xAB at 0x80000001.
  - Response: mem_wdata=0x0000_AB00, mem_wmask=4'b0010, mem_wen=1; resp_rdata=0 after mem_rvalid.
- Misaligned word:
  - Stimulus: sw at 0x80000002.
  - Response: no mem_valid, resp_valid next cycle with err=1.
- Bus error and timeout:
  - Stimulus: mem_err=1 with rvalid.
  - Response: err=2, rdata=0.
  - Stimulus: TIMEOUT=8 and no mem_ready.
  - Response: mem_valid drops, err=3 after 8 cycles in REQ.
- Backpressure and reset:
  - Stimulus: hold resp_ready=0 for 5 cycles.
  - Response: resp fields stable.
  - Stimulus: assert rst during WAIT.
  - Response: immediate IDLE/reset values; a later mem_rvalid is ignored.

Source files
------------

// File: rtl/ysyx_25070198_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ysyx_25070198_pkg
//  Purpose  : Shared types and codes for the load/store unit: FSM state
//             encoding, access size codes and response error codes.
//  Revision : 1.0 - initial release
// ============================================================================
package ysyx_25070198_pkg;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2,
        LSU_RESP = 2'd3
    } lsu_state_e;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam logic [1:0] LSU_OK       = 2'd0;
    localparam logic [1:0] LSU_MISALIGN = 2'd1;
    localparam logic [1:0] LSU_BUSERR   = 2'd2;
    localparam logic [1:0] LSU_TIMEOUT  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/ysyx_25070198_lsu_align.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ysyx_25070198_lsu_align
//  Purpose  : Combinational byte-lane steering. Stores: shift data into its
//             lanes and build the byte-enable. Loads: shift the addressed
//             bytes down and sign/zero-extend to XLEN.
//  Revision : 1.0 - initial release
// ============================================================================
module ysyx_25070198_lsu_align
    import ysyx_25070198_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]                   size,
    input  logic                         is_unsigned,
    input  logic [$clog2(XLEN/8)-1:0]    off,
    input  logic [XLEN-1:0]              st_data_in,
    input  logic [XLEN-1:0]              ld_data_in,
    output logic [XLEN-1:0]              st_data,
    output logic [XLEN/8-1:0]            st_mask,
    output logic [XLEN-1:0]              ld_data
);

    localparam int NB = XLEN / 8;

    logic [NB-1:0]   w_mask_base;
    logic [XLEN-1:0] w_ld_shift;
    logic            w_sign;
    logic            w_fill;

    // Byte-enable for an access of 2^size bytes starting at lane 0
    always_comb begin
        w_mask_base = '0;
        for (int i = 0; i < NB; i++) begin
            if (i < (1 << size)) w_mask_base[i] = 1'b1;
        end
    end

    assign st_mask    = w_mask_base << off;
    assign st_data    = st_data_in << {off, 3'b000};
    assign w_ld_shift = ld_data_in >> {off, 3'b000};

    // Pick the top bit of the accessed field and fill everything above it
    always_comb begin
        w_sign  = 1'b0;
        w_fill  = 1'b0;
        ld_data = w_ld_shift;
        case (size)
            SZ_B:    w_sign = w_ld_shift[7];
            SZ_H:    w_sign = w_ld_shift[15];
            SZ_W:    w_sign = w_ld_shift[31];
            default: w_sign = w_ld_shift[XLEN-1];
        endcase
        w_fill = w_sign & ~is_unsigned;
        for (int i = 0; i < XLEN; i++) begin
            if (i >= (8 << size)) ld_data[i] = w_fill;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ysyx_25070198_lsu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ysyx_25070198_lsu
//  Purpose  : Multi-cycle handshaked load/store unit between the EXU and the
//             data-memory bus. One outstanding access; detects misalignment,
//             bus errors and response timeouts.
//  Revision : 1.0 - initial release
// ============================================================================
module ysyx_25070198_lsu
    import ysyx_25070198_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_wen,
    input  logic [1:0]           req_size,
    input  logic                 req_unsigned,
    input  logic [AW-1:0]        req_addr,
    input  logic [XLEN-1:0]      req_wdata,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [XLEN-1:0]      resp_rdata,
    output logic [1:0]           resp_err,
    output logic                 mem_valid,
    input  logic                 mem_ready,
    output logic                 mem_wen,
    output logic [AW-1:0]        mem_addr,
    output logic [XLEN-1:0]      mem_wdata,
    output logic [XLEN/8-1:0]    mem_wmask,
    input  logic                 mem_rvalid,
    input  logic [XLEN-1:0]      mem_rdata,
    input  logic                 mem_err
);

    localparam int OFFW = $clog2(XLEN / 8);
    localparam int CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] c_cnt_last = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] c_cnt_max  = CW'(TIMEOUT);

    lsu_state_e         r_state;
    lsu_state_e         w_state_nxt;
    logic               r_wen;
    logic [1:0]         r_size;
    logic               r_unsigned;
    logic [AW-1:0]      r_addr;
    logic [XLEN-1:0]    r_wdata;
    logic [XLEN-1:0]    r_rdata;
    logic [1:0]         r_err;
    logic [CW-1:0]      r_cnt;

    logic               w_misalign;
    logic               w_expired;
    logic [CW-1:0]      w_cnt_inc;
    logic [XLEN-1:0]    w_st_data;
    logic [XLEN/8-1:0]  w_st_mask;
    logic [XLEN-1:0]    w_ld_data;

    ysyx_25070198_lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .size        (r_size),
        .is_unsigned (r_unsigned),
        .off         (r_addr[OFFW-1:0]),
        .st_data_in  (r_wdata),
        .ld_data_in  (mem_rdata),
        .st_data     (w_st_data),
        .st_mask     (w_st_mask),
        .ld_data     (w_ld_data)
    );

    // Natural alignment check on the incoming request; D is illegal on RV32
    always_comb begin
        w_misalign = 1'b0;
        case (req_size)
            SZ_B:    w_misalign = 1'b0;
            SZ_H:    w_misalign = req_addr[0];
            SZ_W:    w_misalign = |req_addr[1:0];
            default: w_misalign = (XLEN == 32) || (|req_addr[2:0]);
        endcase
    end

    // r_cnt counts cycles already spent in REQ+WAIT; this cycle is the last allowed one
    assign w_expired = (r_cnt >= c_cnt_last);
    assign w_cnt_inc = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + 1'b1;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= LSU_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next-state logic; a bus handshake or response beats a coincident timeout
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            LSU_IDLE: if (req_valid) w_state_nxt = w_misalign ? LSU_RESP : LSU_REQ;
            LSU_REQ: begin
                if (mem_ready)      w_state_nxt = LSU_WAIT;
                else if (w_expired) w_state_nxt = LSU_RESP;
            end
            LSU_WAIT: if (mem_rvalid || w_expired) w_state_nxt = LSU_RESP;
            LSU_RESP: if (resp_ready) w_state_nxt = LSU_IDLE;
            default:  w_state_nxt = LSU_IDLE;
        endcase
    end

    // Request capture, timeout counting and result/error capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wen      <= 1'b0;
            r_size     <= SZ_B;
            r_unsigned <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_err      <= LSU_OK;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                LSU_IDLE: begin
                    if (req_valid) begin
                        r_wen      <= req_wen;
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_addr     <= req_addr;
                        r_wdata    <= req_wdata;
                        r_rdata    <= '0;
                        r_err      <= w_misalign ? LSU_MISALIGN : LSU_OK;
                        r_cnt      <= '0;
                    end
                end
                LSU_REQ: begin
                    r_cnt <= w_cnt_inc;
                    if (!mem_ready && w_expired) r_err <= LSU_TIMEOUT;
                end
                LSU_WAIT: begin
                    r_cnt <= w_cnt_inc;
                    if (mem_rvalid) begin
                        if (mem_err) begin
                            r_err   <= LSU_BUSERR;
                            r_rdata <= '0;
                        end else begin
                            r_err   <= LSU_OK;
                            r_rdata <= r_wen ? '0 : w_ld_data;
                        end
                    end else if (w_expired) begin
                        r_err <= LSU_TIMEOUT;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready  = (r_state == LSU_IDLE);
    assign resp_valid = (r_state == LSU_RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;
    assign mem_valid  = (r_state == LSU_REQ);
    assign mem_wen    = r_wen;
    assign mem_addr   = {r_addr[AW-1:OFFW], {OFFW{1'b0}}};
    assign mem_wdata  = w_st_data;
    assign mem_wmask  = r_wen ? w_st_mask : '0;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25070198_lsu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_ysyx_25070198_lsu
//  Purpose  : Scoreboard bench for the load/store unit (XLEN=32, TIMEOUT=8):
//             directed cases plus randomized traffic against a byte-level
//             reference model, with a scripted bus responder.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_25070198_lsu;
    import ysyx_25070198_pkg::*;

    localparam int XLEN    = 32;
    localparam int AW      = 32;
    localparam int TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_ready, req_wen, req_unsigned;
    logic [1:0]        req_size;
    logic [AW-1:0]     req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic              resp_valid, resp_ready;
    logic [XLEN-1:0]   resp_rdata;
    logic [1:0]        resp_err;
    logic              mem_valid, mem_ready, mem_wen, mem_rvalid, mem_err;
    logic [AW-1:0]     mem_addr;
    logic [XLEN-1:0]   mem_wdata, mem_rdata;
    logic [XLEN/8-1:0] mem_wmask;

    ysyx_25070198_lsu #(.XLEN(XLEN), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bus modes: 0 normal, 1 never accepted, 2 accepted but never answered,
    // 3 accepted then answered only after the unit has been reset
    typedef struct { logic [31:0] rdata; logic [1:0] err; int due; } exp_t;
    typedef struct {
        int mode; int rdy_dly; int rv_dly;
        logic [31:0] rdata; logic err;
        logic [31:0] addr; logic wen; logic [31:0] wdata; logic [3:0] wmask;
    } bus_t;

    exp_t exp_q[$];
    bus_t bus_q[$];
    int   checks = 0;
    int   errors = 0;
    int   stall_req = 0;
    bit   rst_done = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_ready"},  64'(req_ready),  64'd1);
        chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
        chk({tag, "_mem_valid"},  64'(mem_valid),  64'd0);
        chk({tag, "_mem_wen"},    64'(mem_wen),    64'd0);
        chk({tag, "_resp_err"},   64'(resp_err),   64'd0);
        chk({tag, "_resp_rdata"}, 64'(resp_rdata), 64'd0);
        chk({tag, "_mem_addr"},   64'(mem_addr),   64'd0);
        chk({tag, "_mem_wdata"},  64'(mem_wdata),  64'd0);
        chk({tag, "_mem_wmask"},  64'(mem_wmask),  64'd0);
    endtask

    // Wait for the unit, compute the expected outcome from the access rules,
    // queue it, and present the request for one accepted cycle.
    task automatic issue(input bit wen, input logic [1:0] size, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int mode, input int rdy, input int rv,
                         input logic [31:0] brd, input bit berr);
        int     n, off, k;
        exp_t   e;
        bus_t   b;
        longint val;
        @(negedge clk);
        k = 0;
        while (!req_ready && k < 300) begin @(negedge clk); k++; end
        if (!req_ready) begin chk("req_ready_wait", 64'd0, 64'd1); return; end
        n = 1 << size;
        off = int'(addr % 4);
        e.due = 0;
        if (size == SZ_D || (addr % n) != 0) begin
            e.rdata = '0; e.err = 2'd1; e.due = cyc + 1;
            exp_q.push_back(e);
        end else begin
            b.mode = mode; b.rdy_dly = rdy; b.rv_dly = rv; b.rdata = brd; b.err = berr;
            b.addr = addr & 32'hFFFF_FFFC; b.wen = wen; b.wmask = '0; b.wdata = '0;
            for (int j = 0; j < 4; j++) begin
                if (j >= off && j < off + n) b.wmask[j] = 1'b1;
                if (j >= off) b.wdata[8*j +: 8] = wdata[8*(j-off) +: 8];
            end
            bus_q.push_back(b);
            if (mode == 1 || mode == 2) begin
                e.rdata = '0; e.err = 2'd3; e.due = cyc + 1 + TIMEOUT;
                exp_q.push_back(e);
            end else if (mode == 0) begin
                e.due = cyc + rdy + rv + 3;
                if (berr) begin
                    e.rdata = '0; e.err = 2'd2;
                end else if (wen) begin
                    e.rdata = '0; e.err = 2'd0;
                end else begin
                    val = 0;
                    for (int q = 0; q < n; q++)
                        val += longint'((brd >> (8*(off+q))) & 32'hFF) << (8*q);
                    if (!uns && val >= (longint'(1) << (8*n-1))) val -= longint'(1) << (8*n);
                    e.rdata = val[31:0]; e.err = 2'd0;
                end
                exp_q.push_back(e);
            end
        end
        req_valid = 1'b1; req_wen = wen; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
        req_wen = 1'($urandom); req_size = 2'($urandom);
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || !req_ready) && k < 300) begin @(negedge clk); k++; end
        if (exp_q.size() != 0 || !req_ready) chk("wait_done_timeout", 64'd0, 64'd1);
    endtask

    // Response monitor: pops an expectation on each new response, checks it
    // every cycle the response is held, and drives resp_ready
    initial begin
        exp_t cur;
        bit   in_resp, have;
        int   hold;
        in_resp = 1'b0; have = 1'b0; hold = 0;
        cur.rdata = '0; cur.err = '0; cur.due = 0;
        resp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (resp_valid) begin
                if (!in_resp) begin
                    in_resp = 1'b1;
                    if (exp_q.size() == 0) begin
                        have = 1'b0;
                        chk("unexpected_resp", 64'd1, 64'd0);
                    end else begin
                        have = 1'b1;
                        cur = exp_q.pop_front();
                        chk("resp_rdata", 64'(resp_rdata), 64'(cur.rdata));
                        chk("resp_err", 64'(resp_err), 64'(cur.err));
                        chk("resp_latency", 64'(cyc), 64'(cur.due));
                        chk("req_ready_busy", 64'(req_ready), 64'd0);
                    end
                    hold = (stall_req > 0) ? stall_req : int'($urandom_range(0, 2));
                    stall_req = 0;
                end else if (have) begin
                    chk("held_rdata", 64'(resp_rdata), 64'(cur.rdata));
                    chk("held_err", 64'(resp_err), 64'(cur.err));
                end
                if (hold > 0) begin
                    resp_ready = 1'b0; hold--;
                end else begin
                    resp_ready = 1'b1; in_resp = 1'b0;
                end
            end else begin
                in_resp = 1'b0;
                resp_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    // Bus responder: checks each request against the expected lanes and
    // replays the scripted handshake timing
    initial begin
        bus_t b;
        int   n;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0; mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_valid) begin
                if (bus_q.size() == 0) begin
                    chk("unexpected_mem_valid", 64'd1, 64'd0);
                    n = 0;
                    while (mem_valid && n < 50) begin @(negedge clk); n++; end
                end else begin
                    b = bus_q.pop_front();
                    chk("mem_addr", 64'(mem_addr), 64'(b.addr));
                    chk("mem_wen", 64'(mem_wen), 64'(b.wen));
                    chk("mem_wmask", 64'(mem_wmask), b.wen ? 64'(b.wmask) : 64'd0);
                    if (b.wen) chk("mem_wdata", 64'(mem_wdata), 64'(b.wdata));
                    if (b.mode == 1) begin
                        n = 0;
                        while (mem_valid && n < TIMEOUT + 20) begin n++; @(negedge clk); end
                        chk("req_timeout_cycles", 64'(n), 64'(TIMEOUT));
                    end else begin
                        repeat (b.rdy_dly) begin
                            chk("mem_valid_held", 64'(mem_valid), 64'd1);
                            @(negedge clk);
                        end
                        mem_ready = 1'b1;
                        if (b.mode == 0 && $urandom_range(0, 3) == 0) begin
                            mem_rvalid = 1'b1; mem_err = 1'($urandom); mem_rdata = $urandom;
                        end
                        @(negedge clk);
                        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0;
                        if (b.mode == 0) begin
                            repeat (b.rv_dly) @(negedge clk);
                            mem_rvalid = 1'b1; mem_rdata = b.rdata; mem_err = b.err;
                            @(negedge clk);
                            mem_rvalid = 1'b0; mem_err = 1'b0; mem_rdata = $urandom;
                        end else if (b.mode == 3) begin
                            n = 0;
                            while (!rst_done && n < 200) begin @(negedge clk); n++; end
                            mem_rvalid = 1'b1; mem_rdata = $urandom;
                            @(negedge clk);
                            mem_rvalid = 1'b0;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    // Main stimulus
    initial begin
        int r, md;
        rst = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_size = '0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b1;

        issue(0, SZ_B, 1, 32'h8000_0003, 32'h0, 0, 0, 0, 32'h80FF_1234, 0); wait_done();
        issue(0, SZ_H, 0, 32'h8000_0002, 32'h0, 0, 0, 0, 32'h8001_0000, 0); wait_done();
        issue(1, SZ_B, 0, 32'h8000_0001, 32'h0000_00AB, 0, 0, 0, $urandom, 0); wait_done();
        issue(1, SZ_W, 0, 32'h8000_0002, $urandom, 0, 0, 0, $urandom, 0); wait_done();
        issue(0, SZ_D, 0, 32'h8000_0000, $urandom, 0, 0, 0, $urandom, 0); wait_done();
        issue(0, SZ_W, 0, 32'h8000_0004, 32'h0, 0, 1, 1, 32'h1234_5678, 1); wait_done();
        issue(1, SZ_H, 0, 32'h8000_0006, 32'h0000_BEEF, 1, 0, 0, $urandom, 0); wait_done();
        issue(0, SZ_W, 0, 32'h8000_0008, 32'h0, 2, 2, 0, $urandom, 0); wait_done();
        issue(0, SZ_B, 0, 32'h8000_0005, 32'h0, 0, 3, 3, 32'h0000_F700, 0); wait_done();
        stall_req = 5;
        issue(0, SZ_H, 1, 32'h8000_0006, 32'h0, 0, 0, 0, 32'hCAFE_1234, 0); wait_done();

        // Reset while the access sits in WAIT; the late bus response must be ignored
        issue(0, SZ_W, 0, 32'h8000_0010, 32'h0, 3, 0, 0, $urandom, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_reset_vals("midreset");
        @(negedge clk);
        rst = 1'b1;
        rst_done = 1'b1;
        repeat (8) @(negedge clk);
        chk("post_reset_ready", 64'(req_ready), 64'd1);
        chk("post_reset_resp_valid", 64'(resp_valid), 64'd0);
        rst_done = 1'b0;

        for (int i = 0; i < 300; i++) begin
            r  = int'($urandom_range(0, 19));
            md = (r == 0) ? 1 : (r == 1) ? 2 : 0;
            issue(1'($urandom), 2'($urandom), 1'($urandom),
                  32'h8000_0000 + ($urandom & 32'hFF), $urandom, md,
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  $urandom, $urandom_range(0, 9) == 0);
            wait_done();
        end

        repeat (5) @(negedge clk);
        chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
        chk("bus_q_empty", 64'(bus_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
